fp16_to_int16_pipe: RTL and testbench
=====================================

Name: fp16_to_int16_pipe

Overview:
- Three-stage pipelined converter from IEEE-754 binary16 to signed 16-bit two's-complement integer.
- Inverse of the int-to-fp16 normalisation path: uses the exponent as a bit position to de-normalise the significand back to an integer.
- Sits at the output of the fp16 datapath and feeds integer consumers.
- Valid/ready handshake on both sides; full backpressure support.

Parameters:
- ROUND_NE, 0 — rounding mode: 0 = truncate toward zero, 1 = round-to-nearest-even.
- SATURATE, 1 — overflow handling: 1 = clamp to 0x7FFF/0x8000, 0 = output 0x0000. o_ovf is raised in both cases.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_data  input  16  fp16 operand: sign[15], exp[14:10], mant[9:0].
- i_vld  input  1  input valid.
- o_rdy  output  1  converter can accept input.
- o_data  output  16  signed integer result.
- o_ovf  output  1  result saturated (|x| out of range, or ±Inf).
- o_inv  output  1  operand was NaN.
- o_inx  output  1  result inexact (fraction discarded or rounded).
- o_vld  output  1  output valid.
- i_rdy  input  1  downstream accepts output.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - All stage valid bits cleared.
  - o_vld=0, o_data=0x0000, o_ovf=o_inv=o_inx=0.
  - Reset mid-stream discards all in-flight items; o_rdy=1 on the first cycle after reset.
- Handshake:
  - Global advance enable: adv = ~o_vld | i_rdy.
  - o_rdy = adv.
  - Transfer in when i_vld & o_rdy; transfer out when o_vld & i_rdy.
  - When adv=0, every stage holds; o_data and flags stay stable while o_vld & ~i_rdy.
  - Bubbles are not collapsed.
- Latency: 3 cycles from input transfer to o_vld with no stall. Throughput is 1 per cycle with i_rdy held high.
- Stage 1 (unpack/classify), with e = exp field:
  - e=31, mant≠0: NaN.
  - e=31, mant=0: Inf.
  - e=0: zero or subnormal, magnitude 0; o_inx=1 if mant≠0.
  - Otherwise: significand sig = {1, mant} (11 bits).
- Stage 2 (shift):
  - e≥25: mag = sig << (e−25), computed in a 17-bit field.
  - e<25: mag = sig >> (25−e), retaining a guard bit and a sticky bit.
  - e<15: integer part is 0.
  - e=30 gives mag ≥ 2^15; e≥31 is handled by class, not by shifting.
  - RNE (ROUND_NE=1): increment mag if guard & (sticky | lsb).
  - o_inx = guard | sticky, with either rounding mode.
- Stage 3 (sign/saturate):
  - Positive range: mag ≤ 32767.
  - Negative range: mag ≤ 32768; result is −mag.
  - Out of range or Inf: o_ovf=1; result 0x7FFF (positive) or 0x8000 (negative) when SATURATE=1, else 0x0000.
  - NaN: o_data=0x0000, o_inv=1, o_ovf=0, o_inx=0.
  - −0 produces 0x0000.
- Flags travel with their data word and are valid only while o_vld=1.

Test Plan:
- Exact values, ROUND_NE=0:
  - 0x3C00 (1.0) -> 0x0001.
  - 0x7BFF (65504) -> 0x7FFF, o_ovf=1.
  - 0x77FF (32752) -> 0x7FF0.
  - 0xF800 (−32768) -> 0x8000, o_ovf=0.
  - 0x7800 (32768) -> 0x7FFF, o_ovf=1.
  - Each output appears exactly 3 cycles after input.
- Rounding, same inputs under both modes: 0x4100 (2.5), 0x4300 (3.5), 0xC100 (−2.5), 0x3A00 (0.75), 0x3800 (0.5).
  - ROUND_NE=0 -> 2, 3, −2, 0, 0.
  - ROUND_NE=1 -> 2, 4, −2, 1, 0.
  - o_inx=1 for every one of these.
- Specials:
  - 0x7C00 -> 0x7FFF, o_ovf=1.
  - 0xFC00 -> 0x8000, o_ovf=1.
  - 0x7E00 -> 0x0000, o_inv=1.
  - 0x0001 -> 0x0000, o_inx=1.
  - 0x8000 -> 0x0000, no flags.
  - With SATURATE=0: 0x7C00 -> 0x0000, o_ovf=1.
- Backpressure:
  - Stimulus: stream 0x3C00, 0x4000, 0x4200, 0x4400 back-to-back; drop i_rdy for 5 cycles starting when the first o_vld rises.
  - Output: exactly 1, 2, 3, 4 in order, with o_data held constant during the stall.
  - o_rdy=0 for the whole stall; no loss and no duplication.
- Continuous stream: 256 random operands with i_rdy toggling pseudo-randomly -> every output matches the reference model, in order.
- Reset: assert i_rst_n=0 for 1 cycle while 3 items are in flight and o_vld=1 -> next cycle o_vld=0, o_data=0, all flags 0, o_rdy=1; none of the 3 items ever appear at the output.

Source files
------------

// File: rtl/fp16_to_int16_pipe.sv
// fp16 -> int16 converter: unpack/classify, de-normalising shift with rounding, then sign/saturate.
// Latency 3 cycles, throughput 1 per cycle.
// Backpressure: one global advance (~o_vld | i_rdy) stalls every stage together; bubbles are kept.
module fp16_to_int16_pipe #(
    parameter bit ROUND_NE = 1'b0,
    parameter bit SATURATE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_data,
    input  logic        i_vld,
    output logic        o_rdy,
    output logic [15:0] o_data,
    output logic        o_ovf,
    output logic        o_inv,
    output logic        o_inx,
    output logic        o_vld,
    input  logic        i_rdy
);

    typedef struct packed {
        logic        sign;
        logic        nan;
        logic        inf;
        logic        zero;
        logic        sub;
        logic [4:0]  exp;
        logic [10:0] sig;
    } s1_t;

    typedef struct packed {
        logic        sign;
        logic        nan;
        logic        inf;
        logic        inx;
        logic [16:0] mag;
    } s2_t;

    logic adv;
    logic s1_vld, s2_vld;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    assign adv   = ~o_vld | i_rdy;
    assign o_rdy = adv;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = i_data[15];
        s1_d.exp  = i_data[14:10];
        s1_d.sig  = {1'b1, i_data[9:0]};
        s1_d.nan  = (&i_data[14:10]) & (|i_data[9:0]);
        s1_d.inf  = (&i_data[14:10]) & ~(|i_data[9:0]);
        s1_d.zero = ~(|i_data[14:10]);
        s1_d.sub  = ~(|i_data[14:10]) & (|i_data[9:0]);
    end

    // Fixed point with 24 fraction bits: value = sig * 2^(e-25) = (sig << (e-1)) * 2^-24.
    logic [39:0] wide;
    logic [15:0] int_part;
    logic        guard, sticky, round_up;

    always_comb begin
        wide      = {29'd0, s1_q.sig} << (s1_q.exp - 5'd1);
        int_part  = wide[39:24];
        guard     = wide[23];
        sticky    = |wide[22:0];
        round_up  = ROUND_NE & guard & (sticky | int_part[0]);
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.nan  = s1_q.nan;
        s2_d.inf  = s1_q.inf;
        if (s1_q.nan | s1_q.inf | s1_q.zero) begin
            s2_d.mag = '0;
            s2_d.inx = s1_q.sub;
        end else begin
            s2_d.mag = {1'b0, int_part} + {16'd0, round_up};
            s2_d.inx = guard | sticky;
        end
    end

    logic [15:0] s3_data;
    logic        s3_ovf, s3_inv, s3_inx, over;

    always_comb begin
        over    = s2_q.inf | (s2_q.sign ? (s2_q.mag > 17'd32768) : (s2_q.mag > 17'd32767));
        s3_data = 16'h0000;
        s3_ovf  = 1'b0;
        s3_inv  = 1'b0;
        s3_inx  = 1'b0;
        if (s2_q.nan) begin
            s3_inv = 1'b1;
        end else if (over) begin
            s3_ovf  = 1'b1;
            s3_inx  = s2_q.inx;
            s3_data = SATURATE ? (s2_q.sign ? 16'h8000 : 16'h7FFF) : 16'h0000;
        end else begin
            s3_inx  = s2_q.inx;
            s3_data = s2_q.sign ? (~s2_q.mag[15:0] + 16'd1) : s2_q.mag[15:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
            s2_vld <= 1'b0;
            s2_q   <= '0;
            o_vld  <= 1'b0;
            o_data <= 16'h0000;
            o_ovf  <= 1'b0;
            o_inv  <= 1'b0;
            o_inx  <= 1'b0;
        end else if (adv) begin
            s1_vld <= i_vld;
            s1_q   <= s1_d;
            s2_vld <= s1_vld;
            s2_q   <= s2_d;
            o_vld  <= s2_vld;
            o_data <= s3_data;
            o_ovf  <= s3_ovf;
            o_inv  <= s3_inv;
            o_inx  <= s3_inx;
        end
    end

endmodule

// File: tb/tb_fp16_to_int16_pipe.sv
// Bench for fp16_to_int16_pipe: three instances (truncate+sat, RNE+sat, truncate+no-sat) share stimulus.
module tb_fp16_to_int16_pipe;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_vld;
    logic        out_rdy;
    logic [2:0]  rdy, vld, ovf, inv, inx;
    logic [15:0] dat [3];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
        logic        inv;
        logic        inx;
    } res_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] q_tr;
        logic [15:0] q_rne;
        logic [15:0] q_ns;
        logic        ovf;
        logic        inv;
        logic        inx;
    } vec_t;

    fp16_to_int16_pipe #(.ROUND_NE(1'b0), .SATURATE(1'b1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(in_data), .i_vld(in_vld), .o_rdy(rdy[0]),
        .o_data(dat[0]), .o_ovf(ovf[0]), .o_inv(inv[0]), .o_inx(inx[0]), .o_vld(vld[0]), .i_rdy(out_rdy));
    fp16_to_int16_pipe #(.ROUND_NE(1'b1), .SATURATE(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(in_data), .i_vld(in_vld), .o_rdy(rdy[1]),
        .o_data(dat[1]), .o_ovf(ovf[1]), .o_inv(inv[1]), .o_inx(inx[1]), .o_vld(vld[1]), .i_rdy(out_rdy));
    fp16_to_int16_pipe #(.ROUND_NE(1'b0), .SATURATE(1'b0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(in_data), .i_vld(in_vld), .o_rdy(rdy[2]),
        .o_data(dat[2]), .o_ovf(ovf[2]), .o_inv(inv[2]), .o_inx(inx[2]), .o_vld(vld[2]), .i_rdy(out_rdy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    // Reference: exact value sig * 2^(e-25) split into quotient and remainder.
    function automatic res_t ref_conv(input logic [15:0] x, input bit rne, input bit sat);
        res_t r;
        int   e, m, sig, sh, q, rem, half;
        bit   s;
        r = '0;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        s = x[15];
        if (e == 31) begin
            if (m != 0) r.inv = 1'b1;
            else begin
                r.ovf  = 1'b1;
                r.data = sat ? (s ? 16'h8000 : 16'h7FFF) : 16'h0000;
            end
            return r;
        end
        if (e == 0) begin
            r.inx = (m != 0);
            return r;
        end
        sig = 1024 + m;
        if (e >= 25) q = sig * (1 << (e - 25));
        else begin
            sh   = 25 - e;
            q    = sig / (1 << sh);
            rem  = sig % (1 << sh);
            half = 1 << (sh - 1);
            r.inx = (rem != 0);
            if (rne && (rem > half || (rem == half && (q % 2) == 1))) q++;
        end
        if ((!s && q > 32767) || (s && q > 32768)) begin
            r.ovf  = 1'b1;
            r.data = sat ? (s ? 16'h8000 : 16'h7FFF) : 16'h0000;
        end else begin
            r.data = s ? 16'(-q) : 16'(q);
        end
        return r;
    endfunction

    logic [15:0] exp_q [$];
    logic [15:0] seen_q [$];
    bit          log_en = 1'b0;
    logic [15:0] mon_d;
    res_t        mon_r;

    // Scoreboard: sampled at negedge, pushes accepted inputs and checks every transferred output.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (vld[0] && out_rdy) begin
                if (log_en) seen_q.push_back(dat[0]);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h want no output", dat[0]);
                end else begin
                    mon_d = exp_q.pop_front();
                    for (int i = 0; i < 3; i++) begin
                        mon_r = ref_conv(mon_d, i == 1, i != 2);
                        chk($sformatf("model_data%0d in=%h", i, mon_d), 32'(dat[i]), 32'(mon_r.data));
                        chk($sformatf("model_flags%0d in=%h", i, mon_d),
                            32'({ovf[i], inv[i], inx[i]}), 32'({mon_r.ovf, mon_r.inv, mon_r.inx}));
                    end
                end
            end
            if (in_vld && rdy[0]) exp_q.push_back(in_data);
        end
    end

    task automatic send(input logic [15:0] d);
        bit ok = 1'b0;
        in_data = d;
        in_vld  = 1'b1;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            ok = rdy[0];
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got rdy=0 want rdy=1");
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        in_data = v.din;
        in_vld  = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        @(negedge clk);
        chk($sformatf("lat1 in=%h", v.din), 32'(vld), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("lat2 in=%h", v.din), 32'(vld), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("lat3 in=%h", v.din), 32'(vld), 32'b111);
        chk($sformatf("tbl_tr in=%h", v.din), 32'(dat[0]), 32'(v.q_tr));
        chk($sformatf("tbl_rne in=%h", v.din), 32'(dat[1]), 32'(v.q_rne));
        chk($sformatf("tbl_ns in=%h", v.din), 32'(dat[2]), 32'(v.q_ns));
        for (int i = 0; i < 3; i++)
            chk($sformatf("tbl_flags%0d in=%h", i, v.din),
                32'({ovf[i], inv[i], inx[i]}), 32'({v.ovf, v.inv, v.inx}));
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [15];
    bit   rand_done;

    initial begin
        //            din       trunc     rne       nosat     ovf   inv   inx
        vecs[0]  = '{16'h3C00, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h7BFF, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h77FF, 16'h7FF0, 16'h7FF0, 16'h7FF0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'hF800, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h7800, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'h4100, 16'h0002, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'h4300, 16'h0003, 16'h0004, 16'h0003, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'hC100, 16'hFFFE, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{16'h3A00, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{16'h3800, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{16'h7C00, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{16'hFC00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{16'h7E00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};

        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_data = 16'h0000;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vld", 32'(vld), 32'd0);
        chk("reset_rdy", 32'(rdy), 32'b111);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_data%0d", i), 32'(dat[i]), 32'd0);
            chk($sformatf("reset_flags%0d", i), 32'({ovf[i], inv[i], inx[i]}), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[n]) run_vec(vecs[n]);
        drain("drain_table");

        // Backpressure: 4 back-to-back items, downstream stalls 5 cycles once the first appears.
        seen_q.delete();
        log_en = 1'b1;
        fork
            begin
                send(16'h3C00);
                send(16'h4000);
                send(16'h4200);
                send(16'h4400);
            end
            begin
                for (int k = 0; k < 50 && !vld[0]; k++) begin
                    @(posedge clk);
                    #1;
                end
                chk("bp_first_vld", 32'(vld[0]), 32'd1);
                out_rdy = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("bp_stall_rdy%0d", k), 32'(rdy), 32'd0);
                    chk($sformatf("bp_stall_data%0d", k), 32'(dat[0]), 32'h0001);
                    chk($sformatf("bp_stall_vld%0d", k), 32'(vld), 32'b111);
                    @(posedge clk);
                    #1;
                end
                out_rdy = 1'b1;
            end
        join
        drain("drain_bp");
        log_en = 1'b0;
        chk("bp_count", 32'(seen_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < seen_q.size(); k++)
            chk($sformatf("bp_order%0d", k), 32'(seen_q[k]), 32'(k + 1));

        // Random stream with random downstream readiness.
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 256; n++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(16'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_rdy = ($urandom_range(2) != 0);
                end
                out_rdy = 1'b1;
            end
        join
        drain("drain_rand");

        // Reset with three items in flight and the output stalled.
        out_rdy = 1'b0;
        send(16'h3C00);
        send(16'h4000);
        send(16'h4200);
        chk("rst_pre_vld", 32'(vld), 32'b111);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_vld", 32'(vld), 32'd0);
        chk("rst_mid_rdy", 32'(rdy), 32'b111);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_mid_data%0d", i), 32'(dat[i]), 32'd0);
            chk($sformatf("rst_mid_flags%0d", i), 32'({ovf[i], inv[i], inx[i]}), 32'd0);
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rst_flushed%0d", k), 32'(vld), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
